// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the two-requester ALU arbiter: ALU ops, FSM states,
// condition-code bit positions.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // OF is only meaningful for the arithmetic ops
    function automatic logic op_is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_cc;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_cc
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_cc
    );
endinterface

// File: rtl/alu_arbiter_alu_wrapper.sv
// Combinational ALU: ADD/SUB/AND/XOR with signed-overflow detect for ADD/SUB.
module alu_wrapper
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_of
);
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Result mux and two's-complement overflow from operand/result sign bits
    always_comb begin
        o_result = {WIDTH{1'b0}};
        o_of     = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = w_sum;
                o_of     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_of     = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: begin
                o_result = {WIDTH{1'b0}};
                o_of     = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// registered result/flags, architectural condition-code register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus,
    output logic [2:0]  cc,
    output logic        busy
);
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_gid;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rsp_data;
    logic [2:0]       r_rsp_cc;
    logic [2:0]       r_cc;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             r_busy;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_done;
    logic [WIDTH-1:0] w_res;
    logic             w_alu_of;
    logic [2:0]       w_flags;

    // When both request, the one not served last wins
    assign w_grant0   = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1   = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    assign w_accept   = (r_state == IDLE) & (w_grant0 | w_grant1);
    assign w_rsp_done = (r_state == RESP) & (r_gid ? bus.rsp1_ready : bus.rsp0_ready);

    assign bus.req0_ready = (r_state == IDLE) & ~rst & w_grant0;
    assign bus.req1_ready = (r_state == IDLE) & ~rst & w_grant1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_cc     = r_rsp_cc;
    assign cc             = r_cc;
    assign busy           = r_busy;

    alu_wrapper #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_res),
        .o_of     (w_alu_of)
    );

    // Flags of the current ALU result; OF only kept for arithmetic ops
    always_comb begin
        w_flags        = 3'b000;
        w_flags[CC_ZF] = (w_res == {WIDTH{1'b0}});
        w_flags[CC_SF] = w_res[WIDTH-1];
        if (op_is_arith(r_op)) begin
            w_flags[CC_OF] = w_alu_of;
        end else begin
            w_flags[CC_OF] = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (w_rsp_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, result/flag registers, response valids and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= ALU_ADD;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_gid        <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_data   <= {WIDTH{1'b0}};
            r_rsp_cc     <= 3'b000;
            r_cc         <= 3'b000;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op         <= alu_op_e'(w_grant1 ? bus.req1_op : bus.req0_op);
                r_a          <= w_grant1 ? bus.req1_a : bus.req0_a;
                r_b          <= w_grant1 ? bus.req1_b : bus.req0_b;
                r_gid        <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_rsp_data   <= w_res;
                r_rsp_cc     <= w_flags;
                r_cc         <= w_flags;
                r_rsp0_valid <= ~r_gid;
                r_rsp1_valid <= r_gid;
            end else if (w_rsp_done) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
            r_busy <= (w_state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter against a transaction-level reference.
module tb_alu_arbiter;
    localparam int W = 64;

    logic       clk;
    logic       rst;
    logic [2:0] cc;
    logic       busy;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cc   (cc),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: phase 0 = free, 1 = computing, 2 = answer pending
    int          m_phase;
    bit          m_last;
    bit          m_gid;
    logic [66:0] m_pend;
    logic [W-1:0] m_data;
    logic [2:0]  m_rcc;
    logic [2:0]  m_cc;
    int          n_resp[2];
    bit          grants[$];

    function automatic logic [66:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [W:0] wide;
        logic [W-1:0] r;
        logic of;
        of = 1'b0;
        case (op)
            2'd0: begin wide = $signed({a[W-1], a}) + $signed({b[W-1], b}); r = wide[W-1:0]; of = wide[W] ^ wide[W-1]; end
            2'd1: begin wide = $signed({a[W-1], a}) - $signed({b[W-1], b}); r = wide[W-1:0]; of = wide[W] ^ wide[W-1]; end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {(r == 64'd0), r[W-1], of, r};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies, advance the reference at the edge, check outputs after it
    task automatic tick();
        logic g0, g1;
        #1;
        g0 = !rst && m_phase == 0 && bus.req0_valid && (!bus.req1_valid || m_last);
        g1 = !rst && m_phase == 0 && bus.req1_valid && (!bus.req0_valid || !m_last);
        check("req0_ready", bus.req0_ready, g0);
        check("req1_ready", bus.req1_ready, g1);
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_last = 1'b1; m_data = '0; m_rcc = 3'b000; m_cc = 3'b000;
        end else begin
            case (m_phase)
                0: if (g0 || g1) begin
                    m_pend = g1 ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b)
                                : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
                    m_gid  = g1;
                    m_last = g1;
                    grants.push_back(g1);
                    m_phase = 1;
                end
                1: begin
                    m_data  = m_pend[W-1:0];
                    m_rcc   = m_pend[66:64];
                    m_cc    = m_pend[66:64];
                    m_phase = 2;
                end
                default: if (m_gid ? bus.rsp1_ready : bus.rsp0_ready) begin
                    n_resp[m_gid]++;
                    m_phase = 0;
                end
            endcase
        end
        @(negedge clk);
        check("busy", busy, m_phase != 0);
        check("rsp0_valid", bus.rsp0_valid, m_phase == 2 && !m_gid);
        check("rsp1_valid", bus.rsp1_valid, m_phase == 2 && m_gid);
        check("rsp_data", bus.rsp_data, m_data);
        check("rsp_cc", bus.rsp_cc, m_rcc);
        check("cc", cc, m_cc);
    endtask

    initial begin
        m_phase = 0; m_last = 1'b1; m_gid = 1'b0; m_pend = '0;
        m_data = '0; m_rcc = 3'b000; m_cc = 3'b000;
        n_resp[0] = 0; n_resp[1] = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 64'd5; bus.req0_b = 64'd7;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 64'd9; bus.req1_b = 64'd3;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        @(negedge clk);

        // Reset with both valid, then single ADD 5+7, then backpressure
        tick(); tick();
        check("t1_cc_reset", cc, 3'b000);
        rst = 1'b0;
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        check("t2_add_data", bus.rsp_data, 64'd12);
        check("t2_add_cc", bus.rsp_cc, 3'b000);
        check("t2_rsp0_valid", bus.rsp0_valid, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t5_hold_data", bus.rsp_data, 64'd12);
        bus.rsp0_ready = 1'b1;
        tick();
        check("t5_idle_after", busy, 1'b0);
        bus.rsp0_ready = 1'b0;

        // Contention after reset: grants must alternate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grants.delete();
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 64'd3; bus.req0_b = 64'd5;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 64'hABCD; bus.req1_b = 64'hABCD;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        tick(); tick();
        check("t3_sub_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3_sub_cc", bus.rsp_cc, 3'b010);
        tick(); tick(); tick();
        check("t3_xor_data", bus.rsp_data, 64'd0);
        check("t3_xor_cc", bus.rsp_cc, 3'b100);
        for (int i = 0; i < 7; i++) tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("t3_grant_order", grants[i], i % 2);

        // Signed overflow on ADD, then AND clears OF
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00;
        bus.req1_a = 64'h7FFF_FFFF_FFFF_FFFF; bus.req1_b = 64'd1;
        tick();
        bus.req1_valid = 1'b0;
        tick();
        check("t4_ovf_data", bus.rsp_data, 64'h8000_0000_0000_0000);
        check("t4_ovf_rspcc", bus.rsp_cc, 3'b011);
        check("t4_ovf_cc", cc, 3'b011);
        tick();
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10;
        bus.req0_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.req0_b = 64'd0;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("t4_and_cc", cc, 3'b100);
        tick();

        // Reset during EXEC discards the operation
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 64'd10; bus.req0_b = 64'd3;
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_busy", busy, 1'b0);
        check("t6_cc", cc, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_rsp", bus.rsp0_valid, 1'b0);
        end

        // Randomized traffic with random backpressure and occasional reset
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_op = 2'($urandom_range(0, 3));
            bus.req1_op = 2'($urandom_range(0, 3));
            bus.req0_a = pick_operand(); bus.req0_b = pick_operand();
            bus.req1_a = pick_operand(); bus.req1_b = pick_operand();
            bus.rsp0_ready = ($urandom_range(0, 4) > 1);
            bus.rsp1_ready = ($urandom_range(0, 4) > 1);
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        check("rand_some_rsp0", n_resp[0] > 10, 1'b1);
        check("rand_some_rsp1", n_resp[1] > 10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
